// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: groups the instruction-memory request/response channel, the
// decode handshake and the downstream redirect/halt controls of ifu_fetch.
// When IFU_ALIGN_CHK_EN is defined the bundle also carries misalign_fault.
interface ifu_fetch_if #(
    parameter int XLEN = 64
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_inst;
    logic [XLEN-1:0] out_pc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            halt_req;
    logic            halted;
    logic [63:0]     inst_cnt;
`ifdef IFU_ALIGN_CHK_EN
    logic            misalign_fault;
`endif

    // Fetch unit side
    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        output out_valid,
        output out_inst,
        output out_pc,
        input  out_ready,
        input  redirect_valid,
        input  redirect_pc,
        input  halt_req,
        output halted,
        output inst_cnt
`ifdef IFU_ALIGN_CHK_EN
        ,
        output misalign_fault
`endif
    );

    // Memory / decode side
    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        input  out_valid,
        input  out_inst,
        input  out_pc,
        output out_ready,
        output redirect_valid,
        output redirect_pc,
        output halt_req,
        input  halted,
        input  inst_cnt
`ifdef IFU_ALIGN_CHK_EN
        ,
        input  misalign_fault
`endif
    );
endinterface

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage feeding the decoder. Holds the PC,
// fetches one 32-bit word at a time (request -> wait -> present to decode)
// and takes redirect/halt from decode at the decode handshake.
// Optional macro IFU_ALIGN_CHK_EN: halts with a sticky misalign_fault instead
// of fetching from a PC whose low two bits are non-zero.
module ifu_fetch #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    ifu_fetch_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_OUT,
        S_HALT
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_inst;
    logic [63:0]     r_inst_cnt;

    state_t          w_state_nxt;
    logic [XLEN-1:0] w_pc_nxt;
    logic [31:0]     w_inst_nxt;
    logic [63:0]     w_cnt_nxt;
    logic            w_enter_req;
    logic            w_fire;

`ifdef IFU_ALIGN_CHK_EN
    logic            r_fault;
    logic            w_fault_nxt;
`endif

    assign w_fire = (r_state == S_OUT) && bus.out_ready;

    // Next-state and datapath update; every path into S_REQ goes through w_enter_req
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_inst_nxt  = r_inst;
        w_cnt_nxt   = r_inst_cnt;
        w_enter_req = 1'b0;
`ifdef IFU_ALIGN_CHK_EN
        w_fault_nxt = r_fault;
`endif
        case (r_state)
            S_IDLE: begin
                w_enter_req = 1'b1;
            end
            S_REQ: begin
                if (bus.imem_req_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    w_inst_nxt  = bus.imem_rsp_data;
                    w_state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                if (w_fire) begin
                    w_cnt_nxt = r_inst_cnt + 64'd1;
                    if (bus.halt_req) begin
                        w_state_nxt = S_HALT;
                    end else begin
                        w_pc_nxt    = bus.redirect_valid ? bus.redirect_pc : (r_pc + XLEN'(4));
                        w_enter_req = 1'b1;
                    end
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_enter_req) begin
`ifdef IFU_ALIGN_CHK_EN
            if (w_pc_nxt[1:0] != 2'b00) begin
                w_state_nxt = S_HALT;
                w_fault_nxt = 1'b1;
            end else begin
                w_state_nxt = S_REQ;
            end
`else
            w_state_nxt = S_REQ;
`endif
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_inst     <= 32'd0;
            r_inst_cnt <= 64'd0;
`ifdef IFU_ALIGN_CHK_EN
            r_fault    <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_inst     <= w_inst_nxt;
            r_inst_cnt <= w_cnt_nxt;
`ifdef IFU_ALIGN_CHK_EN
            r_fault    <= w_fault_nxt;
`endif
        end
    end

    assign bus.imem_req_valid = (r_state == S_REQ);
    assign bus.imem_addr      = r_pc;
    assign bus.out_valid      = (r_state == S_OUT);
    assign bus.out_inst       = r_inst;
    assign bus.out_pc         = r_pc;
    assign bus.halted         = (r_state == S_HALT);
    assign bus.inst_cnt       = r_inst_cnt;
`ifdef IFU_ALIGN_CHK_EN
    assign bus.misalign_fault = r_fault;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: randomized scoreboard bench for ifu_fetch. A memory model
// answers fetch requests and pushes the expected {inst, pc} of each accepted
// fetch; a monitor pops and compares at every decode handshake while a
// reference PC/count/halt model follows the fetch rules.
module tb_ifu_fetch;
    localparam int          XLEN     = 64;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [95:0] expQ[$];
    logic [31:0] dataQ[$];
    logic [63:0] expPc     = RESET_PC;
    logic [63:0] expCnt    = 64'd0;
    bit          expHalted = 1'b0;
    bit          expFault  = 1'b0;

    int readyPct    = 100;
    int rspMaxDelay = 0;
    int outReadyPct = 100;
    int redirectPct = 0;
    int haltPct     = 0;
    bit spurious    = 1'b0;

    bit          forceRedirect = 1'b0;
    logic [63:0] forcePc       = 64'd0;

    bit          memPending = 1'b0;
    int          memDelay   = 0;
    logic [31:0] memData    = 32'd0;
    int          rspCycle   = -10;

    bit          prevReqStall = 1'b0;
    bit          prevOutStall = 1'b0;
    bit          prevFire     = 1'b0;
    bit          prevOutValid = 1'b0;
    logic [63:0] prevAddr     = 64'd0;
    logic [63:0] prevPc       = 64'd0;
    logic [31:0] prevInst     = 32'd0;

    ifu_fetch_if #(.XLEN(XLEN)) bus ();

    ifu_fetch #(
        .XLEN    (XLEN),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Decode-side inputs, randomized every cycle; redirect/halt also toggle while not firing
    task automatic applyStimulus();
        logic [31:0] r;
        r = $urandom();
        bus.out_ready      = ($urandom_range(0, 99) < outReadyPct);
        bus.redirect_valid = ($urandom_range(0, 99) < redirectPct);
        if ($urandom_range(0, 7) == 0) bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        else                           bus.redirect_pc = {32'h0, r[31:2], 2'b00};
        bus.halt_req = ($urandom_range(0, 99) < haltPct);
        if (forceRedirect) begin
            bus.out_ready      = 1'b1;
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = forcePc;
            bus.halt_req       = 1'b0;
        end
    endtask

    task automatic checkReset();
        checkOutput("rst_req_valid", bus.imem_req_valid, 0);
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_halted", bus.halted, 0);
        checkOutput("rst_out_pc", bus.out_pc, RESET_PC);
        checkOutput("rst_imem_addr", bus.imem_addr, RESET_PC);
        checkOutput("rst_out_inst", bus.out_inst, 0);
        checkOutput("rst_inst_cnt", bus.inst_cnt, 0);
`ifdef IFU_ALIGN_CHK_EN
        checkOutput("rst_fault", bus.misalign_fault, 0);
`endif
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n     = 1'b0;
        expQ.delete();
        expPc     = RESET_PC;
        expCnt    = 64'd0;
        expHalted = 1'b0;
        expFault  = 1'b0;
        repeat (2) @(negedge clk);
        checkReset();
        rst_n = 1'b1;
    endtask

    task automatic waitFires(input logic [63:0] target, input int limit, input string name);
        int n;
        n = 0;
        while (expCnt < target && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, expCnt >= target, 1);
    endtask

    // Decode driver
    initial begin
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 64'd0;
        bus.halt_req       = 1'b0;
        forever begin
            @(negedge clk);
            applyStimulus();
        end
    end

    // Memory model: accepts requests, answers after a random delay, feeds the scoreboard
    initial begin
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'd0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) memPending = 1'b0;
            if (memPending && memDelay == 0) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = memData;
            end else begin
                if (memPending) memDelay--;
                bus.imem_rsp_valid = !memPending && spurious && ($urandom_range(0, 3) == 0);
                bus.imem_rsp_data  = $urandom();
            end
            bus.imem_req_ready = ($urandom_range(0, 99) < readyPct);
            #2;
            if (rst_n) begin
                if (bus.imem_rsp_valid && memPending) begin
                    memPending = 1'b0;
                    rspCycle   = cyc;
                end
                if (bus.imem_req_valid && bus.imem_req_ready) begin
                    checkOutput("req_addr", bus.imem_addr, expPc);
                    checkOutput("req_while_halted", {63'd0, expHalted}, 0);
                    if (dataQ.size() != 0) memData = dataQ.pop_front();
                    else                   memData = $urandom();
                    memPending = 1'b1;
                    memDelay   = $urandom_range(0, rspMaxDelay);
                    expQ.push_back({memData, expPc});
                end
            end
        end
    end

    // Monitor: scoreboard compare at decode handshakes plus hold/latency/halt checks
    initial begin
        logic [95:0] exp;
        logic [63:0] nxt;
        bit          fire;
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) begin
                prevReqStall = 1'b0;
                prevOutStall = 1'b0;
                prevFire     = 1'b0;
                prevOutValid = 1'b0;
                continue;
            end
            checkOutput("halted", bus.halted, {63'd0, expHalted});
`ifdef IFU_ALIGN_CHK_EN
            checkOutput("misalign_fault", bus.misalign_fault, {63'd0, expFault});
`endif
            if (expHalted) begin
                checkOutput("halt_req_valid", bus.imem_req_valid, 0);
                checkOutput("halt_out_valid", bus.out_valid, 0);
            end
            if (prevReqStall) begin
                checkOutput("req_hold_valid", bus.imem_req_valid, 1);
                checkOutput("req_hold_addr", bus.imem_addr, prevAddr);
            end
            if (prevOutStall) begin
                checkOutput("out_hold_valid", bus.out_valid, 1);
                checkOutput("out_hold_inst", bus.out_inst, prevInst);
                checkOutput("out_hold_pc", bus.out_pc, prevPc);
            end
            if (prevFire && !expHalted) checkOutput("req_after_fire", bus.imem_req_valid, 1);
            if (bus.out_valid && !prevOutValid) checkOutput("rsp_to_out_latency", cyc, rspCycle + 1);
            fire = bus.out_valid && bus.out_ready;
            if (fire) begin
                checkOutput("scoreboard_nonempty", expQ.size() != 0, 1);
                if (expQ.size() != 0) begin
                    exp = expQ.pop_front();
                    checkOutput("out_inst", bus.out_inst, {32'd0, exp[95:64]});
                    checkOutput("out_pc", bus.out_pc, exp[63:0]);
                end
                checkOutput("inst_cnt", bus.inst_cnt, expCnt);
                expCnt = expCnt + 64'd1;
                if (bus.halt_req) begin
                    expHalted = 1'b1;
                end else begin
                    nxt   = bus.redirect_valid ? bus.redirect_pc : expPc + 64'd4;
                    expPc = nxt;
`ifdef IFU_ALIGN_CHK_EN
                    if (nxt[1:0] != 2'b00) begin
                        expHalted = 1'b1;
                        expFault  = 1'b1;
                    end
`endif
                end
            end
            prevReqStall = bus.imem_req_valid && !bus.imem_req_ready;
            prevOutStall = bus.out_valid && !bus.out_ready;
            prevFire     = fire;
            prevOutValid = bus.out_valid;
            prevAddr     = bus.imem_addr;
            prevPc       = bus.out_pc;
            prevInst     = bus.out_inst;
        end
    end

    // Test sequence
    initial begin
        int n;
        logic [63:0] haltCnt;
        dataQ.push_back(32'h00100093);
        doReset();

        // Always-ready memory with single-cycle response: first fetch from RESET_PC
        waitFires(64'd3, 100, "directed_fires");

        // Random back-pressure, response delays, redirects and stray responses
        readyPct    = 60;
        rspMaxDelay = 2;
        outReadyPct = 50;
        redirectPct = 25;
        spurious    = 1'b1;
        n = int'(expCnt);
        repeat (1500) @(negedge clk);
        checkOutput("random_progress", expCnt > 64'(n + 50), 1);

        // Reset in the middle of traffic
        doReset();
        waitFires(64'd20, 1000, "post_reset_fires");

        // A misaligned redirect target: fault+halt with the check, plain fetch without
        @(posedge clk);
        forcePc       = 64'h8000_0102;
        forceRedirect = 1'b1;
        n = 0;
        while (expPc != 64'h8000_0102 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        forceRedirect = 1'b0;
        checkOutput("forced_redirect_taken", expPc, 64'h8000_0102);
        repeat (20) @(negedge clk);

        // Halt request: fetch stops until reset
        doReset();
        haltPct = 10;
        n = 0;
        while (!expHalted && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("halt_seen", {63'd0, expHalted}, 1);
        haltCnt = expCnt;
        repeat (10) @(negedge clk);
        checkOutput("halt_cnt_frozen", bus.inst_cnt, haltCnt);
        haltPct = 0;
        doReset();
        waitFires(64'd10, 500, "after_halt_reset_fires");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch stage directly upstream of the decoder.
- Holds the architectural PC and fetches one 32-bit instruction at a time from instruction memory over a valid/ready request channel and a valid-only response channel.
- Presents {inst, pc} to decode over a valid/ready handshake.
- Accepts the next-PC redirect (jal/jalr) and the halt request (ebreak) from downstream at the decode handshake.

Parameters:
- XLEN, 64, width of PC and addresses.
- RESET_PC, 64'h8000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_addr  out  XLEN  fetch address; equals pc.
- imem_rsp_valid  in  1  response data valid.
- imem_rsp_data  in  32  fetched instruction word.
- out_valid  out  1  {out_inst, out_pc} valid to decode.
- out_ready  in  1  decode accepts.
- out_inst  out  32  instruction to the decoder.
- out_pc  out  XLEN  PC of out_inst.
- redirect_valid  in  1  take redirect_pc as next PC; sampled only on out fire.
- redirect_pc  in  XLEN  target PC (jal/jalr result).
- halt_req  in  1  stop fetching after this instruction; sampled only on out fire.
- halted  out  1  fetch stopped.
- inst_cnt  out  64  count of instructions handed to decode.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=S_IDLE, pc=RESET_PC, inst register=0, inst_cnt=0.
  - imem_req_valid=0, out_valid=0, halted=0, out_pc=RESET_PC, out_inst=0.
  - Reset mid-transaction abandons the transaction; any late imem_rsp_valid is ignored because state is not S_WAIT.
- States: S_IDLE, S_REQ, S_WAIT, S_OUT, S_HALT. All outputs are decoded from registered state; there are no combinational paths from inputs to outputs.
- S_IDLE: one cycle after reset release, then go to S_REQ.
- S_REQ:
  - imem_req_valid=1, imem_addr=pc.
  - Address held stable until imem_req_ready=1, then go to S_WAIT.
- S_WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid=1: latch imem_rsp_data into the inst register, then go to S_OUT.
  - imem_rsp_valid in any other state is ignored.
- S_OUT:
  - out_valid=1, out_inst=inst register, out_pc=pc; both held stable until out_ready=1.
  - out fire = out_valid & out_ready.
- On out fire:
  - inst_cnt += 1, wrapping modulo 2^64.
  - If halt_req=1: go to S_HALT; pc unchanged. halt_req takes priority over redirect_valid.
  - Else if redirect_valid=1: pc<=redirect_pc, go to S_REQ.
  - Else: pc<=pc+4, truncated to XLEN bits (wraps at 2^XLEN), go to S_REQ.
- redirect_valid and halt_req without out fire are ignored.
- S_HALT: halted=1, imem_req_valid=0, out_valid=0; left only by reset.
- Latency:
  - Request accepted at cycle T.
  - Earliest response at T+1.
  - out_valid at T+2.
  - Next request one cycle after out fire.
  - Best-case throughput: one instruction per 3 cycles.
- imem_req_ready=1 outside S_REQ has no effect.

Optional Feature:
- Macro IFU_ALIGN_CHK_EN.
- When defined:
  - Adds output misalign_fault (1 bit, reset 0).
  - Entering S_REQ with pc[1:0]!=0 instead goes to S_HALT with misalign_fault=1 and halted=1; no memory request is issued.
  - misalign_fault is sticky until reset.
- When not defined: no port; pc is fetched unchanged regardless of alignment.

Test Plan:
- Reset then memory with always-ready and 1-cycle response returning 32'h00100093 -> imem_addr=0x80000000 on the first req; out_inst=0x00100093, out_pc=0x80000000; next req addr 0x80000004; inst_cnt=1.
- Hold imem_req_ready=0 for 5 cycles -> imem_req_valid stays 1 with imem_addr stable; no S_WAIT until ready.
- Hold out_ready=0 for 4 cycles in S_OUT -> out_inst and out_pc stable; pc not advanced; inst_cnt unchanged.
- Out fire with redirect_valid=1, redirect_pc=0x80000100 -> next imem_addr=0x80000100. A redirect_valid pulse without out fire -> ignored, next addr is pc+4.
- Out fire with halt_req=1 (ebreak 0x00100073) -> halted=1 next cycle, no further imem_req_valid. Assert rst_n=0 -> halted=0, pc=0x80000000.
- With IFU_ALIGN_CHK_EN, redirect to 0x80000102 -> misalign_fault=1 and halted=1, with no req at 0x80000102.
